// File: rtl/green_pkg.sv
`default_nettype none
// ============================================================================
// Module      : green_pkg
// Description : Opcode and fetch-state encodings shared by the green fetch
//               unit and the green decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package green_pkg;

  localparam logic [3:0] OPC_LD   = 4'b0000;
  localparam logic [3:0] OPC_ST   = 4'b0001;
  localparam logic [3:0] OPC_INC  = 4'b0010;
  localparam logic [3:0] OPC_BR   = 4'b0011;
  localparam logic [3:0] OPC_HALT = 4'b1111;

  localparam logic [1:0] S_FETCH  = 2'd0;
  localparam logic [1:0] S_ISSUE  = 2'd1;
  localparam logic [1:0] S_HALTED = 2'd2;

  typedef enum logic [1:0] {
    ST_FETCH  = S_FETCH,
    ST_ISSUE  = S_ISSUE,
    ST_HALTED = S_HALTED
  } fetch_state_t;

  function automatic logic [3:0] opc_of(input logic [15:0] word);
    return word[15:12];
  endfunction

endpackage
`default_nettype wire

// File: rtl/green_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : green_fetch_if
// Description : Program-memory, opCode-handshake and control signals between
//               the green fetch unit (master) and its environment (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface green_fetch_if #(
  parameter int ADDR_W = 16
);

  logic              start;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [15:0]       mem_rdata;
  logic [15:0]       opCode;
  logic              op_valid;
  logic              op_ready;
  logic              BR_in;
  logic [ADDR_W-1:0] br_target;
  logic [ADDR_W-1:0] pc;
  logic              halted;

  modport master (
    input  start,
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata,
    output opCode,
    output op_valid,
    input  op_ready,
    input  BR_in,
    input  br_target,
    output pc,
    output halted
  );

  modport slave (
    output start,
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata,
    input  opCode,
    input  op_valid,
    output op_ready,
    output BR_in,
    output br_target,
    input  pc,
    input  halted
  );

endinterface
`default_nettype wire

// File: rtl/green_fetch.sv
`default_nettype none
// ============================================================================
// Module      : green_fetch
// Description : Fetches 16-bit instructions at pc, issues them to the decoder
//               with valid/ready, then advances, branches or halts.
// Revision    : 1.0 - initial release
// ============================================================================
module green_fetch
  import green_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  green_fetch_if.master bus
);

  fetch_state_t      r_state;
  fetch_state_t      w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [15:0]       r_ir;
  logic [15:0]       w_ir_nxt;
  logic              r_mem_req;
  logic              r_op_valid;
  logic              r_halted;
  logic              w_fetch_done;
  logic              w_handshake;

  // An ack only counts while a request is actually out, so the cycle right
  // after reset (mem_req low) never captures a stale response.
  assign w_fetch_done = (r_state == ST_FETCH) && r_mem_req && bus.mem_ack;
  assign w_handshake  = (r_state == ST_ISSUE) && r_op_valid && bus.op_ready;
  assign w_pc_inc     = r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ir_nxt    = r_ir;
    case (r_state)
      ST_FETCH: begin
        if (w_fetch_done) begin
          w_ir_nxt    = bus.mem_rdata;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (w_handshake) begin
          case (opc_of(r_ir))
            OPC_HALT: begin
              // pc is left pointing at the HALT word itself.
              w_state_nxt = ST_HALTED;
            end
            OPC_BR: begin
              w_state_nxt = ST_FETCH;
              w_pc_nxt    = bus.BR_in ? bus.br_target : w_pc_inc;
            end
            OPC_LD, OPC_ST, OPC_INC: begin
              w_state_nxt = ST_FETCH;
              w_pc_nxt    = w_pc_inc;
            end
            default: begin
              w_state_nxt = ST_FETCH;
              w_pc_nxt    = w_pc_inc;
            end
          endcase
        end
      end
      ST_HALTED: begin
        if (bus.start) begin
          w_pc_nxt    = RESET_PC;
          w_state_nxt = ST_FETCH;
        end
      end
      default: begin
        w_state_nxt = ST_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_FETCH;
      r_pc       <= RESET_PC;
      r_ir       <= 16'h0000;
      r_mem_req  <= 1'b0;
      r_op_valid <= 1'b0;
      r_halted   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_ir       <= w_ir_nxt;
      r_mem_req  <= (w_state_nxt == ST_FETCH);
      r_op_valid <= (w_state_nxt == ST_ISSUE);
      r_halted   <= (w_state_nxt == ST_HALTED);
    end
  end

  assign bus.mem_req  = r_mem_req;
  assign bus.mem_addr = r_pc;
  assign bus.opCode   = r_ir;
  assign bus.op_valid = r_op_valid;
  assign bus.pc       = r_pc;
  assign bus.halted   = r_halted;

endmodule
`default_nettype wire
